// File: rtl/i2c_reg_bank_if.sv
// Byte-level handshake between an I2C slave PHY and the register bank.
// The PHY side is the master modport; the register bank is the slave.
interface i2c_reg_bank_if;
    logic [7:0] i2c_addr_rw;
    logic       i2c_addr_rw_valid_stb;
    logic [7:0] i2c_data_rx;
    logic       i2c_data_rx_valid_stb;
    logic [7:0] i2c_data_tx;
    logic       i2c_data_tx_done_stb;
    logic       i2c_error_stb;

    modport master (
        output i2c_addr_rw, i2c_addr_rw_valid_stb,
        output i2c_data_rx, i2c_data_rx_valid_stb,
        output i2c_data_tx_done_stb, i2c_error_stb,
        input  i2c_data_tx
    );

    modport slave (
        input  i2c_addr_rw, i2c_addr_rw_valid_stb,
        input  i2c_data_rx, i2c_data_rx_valid_stb,
        input  i2c_data_tx_done_stb, i2c_error_stb,
        output i2c_data_tx
    );
endinterface

// File: rtl/i2c_reg_bank.sv
// I2C-addressable bank of 8-bit registers with an auto-advancing pointer.
// Writable slots are stored here; read-only slots return status_in.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no transaction, data strobes ignored
//   GET_PTR | write transaction, next rx byte loads the pointer
//   WRITE   | rx bytes go to register[pointer], pointer advances
//   READ    | tx_done advances the pointer, i2c_data_tx follows it
module i2c_reg_bank #(
    parameter int                    NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]   WR_MASK    = '1,
    parameter logic [NUM_REGS*8-1:0] RESET_VALS = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    i2c_reg_bank_if.slave           bus,
    input  logic [NUM_REGS*8-1:0]   status_in,
    output logic [NUM_REGS*8-1:0]   regs_out,
    output logic [NUM_REGS-1:0]     reg_wr_stb,
    output logic [7:0]              ptr_out
);

    typedef enum logic [1:0] {IDLE, GET_PTR, WRITE, READ} state_e;

    state_e               state_q, state_d;
    logic [7:0]           ptr_q, ptr_d, ptr_adv;
    logic [7:0]           tx_q, tx_d;
    logic [NUM_REGS-1:0]  stb_q, stb_d;
    logic [7:0]           reg_q [NUM_REGS];
    logic [7:0]           reg_d [NUM_REGS];
    logic [6:0]           unused_addr;

    // Only the R/W bit matters; the PHY has already matched the address.
    assign unused_addr = bus.i2c_addr_rw[7:1];

    always_comb begin
        if (ptr_q == 8'(NUM_REGS - 1))
            ptr_adv = 8'h00;
        else if (ptr_q < 8'(NUM_REGS - 1))
            ptr_adv = ptr_q + 8'h01;
        else
            ptr_adv = ptr_q;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        stb_d   = '0;
        reg_d   = reg_q;
        if (bus.i2c_error_stb) begin
            state_d = IDLE;
        end else if (bus.i2c_addr_rw_valid_stb) begin
            state_d = bus.i2c_addr_rw[0] ? READ : GET_PTR;
        end else begin
            case (state_q)
                GET_PTR: if (bus.i2c_data_rx_valid_stb) begin
                    ptr_d   = bus.i2c_data_rx;
                    state_d = WRITE;
                end
                WRITE: if (bus.i2c_data_rx_valid_stb) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (ptr_q == 8'(k) && WR_MASK[k]) begin
                            reg_d[k] = bus.i2c_data_rx;
                            stb_d[k] = 1'b1;
                        end
                    end
                    ptr_d = ptr_adv;
                end
                READ: if (bus.i2c_data_tx_done_stb) begin
                    ptr_d = ptr_adv;
                end
                default: ;
            endcase
        end
    end

    // Read data follows the registered pointer, so it settles one cycle after it moves.
    always_comb begin
        tx_d = 8'hFF;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ptr_q == 8'(k))
                tx_d = WR_MASK[k] ? reg_q[k] : status_in[k*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 8'h00;
            tx_q    <= 8'h00;
            stb_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++)
                reg_q[k] <= RESET_VALS[k*8 +: 8];
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tx_q    <= tx_d;
            stb_q   <= stb_d;
            reg_q   <= reg_d;
        end
    end

    always_comb begin
        regs_out = '0;
        for (int k = 0; k < NUM_REGS; k++)
            regs_out[k*8 +: 8] = WR_MASK[k] ? reg_q[k] : RESET_VALS[k*8 +: 8];
    end

    assign reg_wr_stb      = stb_q;
    assign ptr_out         = ptr_q;
    assign bus.i2c_data_tx = tx_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank: 4 registers, reg3 read-only status.
module tb_i2c_reg_bank;

    localparam int NR = 4;

    logic            clk;
    logic            rst_n;
    logic [NR*8-1:0] status_in;
    logic [NR*8-1:0] regs_out;
    logic [NR-1:0]   reg_wr_stb;
    logic [7:0]      ptr_out;

    int n_checks;
    int n_pass;

    i2c_reg_bank_if bus ();

    i2c_reg_bank #(
        .NUM_REGS   (NR),
        .WR_MASK    (4'b0111),
        .RESET_VALS ('0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .status_in  (status_in),
        .regs_out   (regs_out),
        .reg_wr_stb (reg_wr_stb),
        .ptr_out    (ptr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // s = {error, tx_done, rx_valid, addr_valid}; data fields are set beforehand.
    task automatic strobe(input logic [3:0] s);
        @(posedge clk); #1;
        bus.i2c_error_stb         = s[3];
        bus.i2c_data_tx_done_stb  = s[2];
        bus.i2c_data_rx_valid_stb = s[1];
        bus.i2c_addr_rw_valid_stb = s[0];
        @(posedge clk); #1;
        bus.i2c_error_stb         = 1'b0;
        bus.i2c_data_tx_done_stb  = 1'b0;
        bus.i2c_data_rx_valid_stb = 1'b0;
        bus.i2c_addr_rw_valid_stb = 1'b0;
    endtask

    task automatic send_addr(input logic [7:0] a);
        bus.i2c_addr_rw = a;
        strobe(4'b0001);
    endtask

    task automatic send_rx(input logic [7:0] d);
        bus.i2c_data_rx = d;
        strobe(4'b0010);
    endtask

    task automatic idle_cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        status_in = {8'h5C, 8'hE2, 8'hE1, 8'hE0};
        bus.i2c_addr_rw           = 8'h00;
        bus.i2c_addr_rw_valid_stb = 1'b0;
        bus.i2c_data_rx           = 8'h00;
        bus.i2c_data_rx_valid_stb = 1'b0;
        bus.i2c_data_tx_done_stb  = 1'b0;
        bus.i2c_error_stb         = 1'b0;

        #3;
        check("rst_ptr",  32'(ptr_out), 32'h0);
        check("rst_regs", regs_out, 32'h0);
        check("rst_stb",  32'(reg_wr_stb), 32'h0);
        check("rst_tx",   32'(bus.i2c_data_tx), 32'h0);
        #9 rst_n = 1'b1;

        // Burst write starting at register 1
        send_addr(8'h84);
        send_rx(8'h01);
        check("wr_ptr_load", 32'(ptr_out), 32'h1);
        send_rx(8'hAA);
        check("wr_stb1",  32'(reg_wr_stb), 32'h2);
        check("wr_reg1",  regs_out, 32'h0000AA00);
        send_rx(8'hBB);
        check("wr_stb2",  32'(reg_wr_stb), 32'h4);
        check("wr_reg2",  regs_out, 32'h00BBAA00);
        check("wr_ptr3",  32'(ptr_out), 32'h3);
        idle_cyc();
        check("wr_stb_clr", 32'(reg_wr_stb), 32'h0);

        // Read from the status slot, wrapping back to register 0
        send_addr(8'h85);
        check("rd_tx_stat", 32'(bus.i2c_data_tx), 32'h5C);
        strobe(4'b0100);
        check("rd_ptr_wrap", 32'(ptr_out), 32'h0);
        idle_cyc();
        check("rd_tx_reg0", 32'(bus.i2c_data_tx), 32'h00);
        strobe(4'b0100);
        check("rd_ptr1", 32'(ptr_out), 32'h1);
        idle_cyc();
        check("rd_tx_reg1", 32'(bus.i2c_data_tx), 32'hAA);

        // Read-only and out-of-range targets
        send_addr(8'h84);
        send_rx(8'h03);
        send_rx(8'h11);
        check("ro_no_stb", 32'(reg_wr_stb), 32'h0);
        check("ro_regs",   regs_out, 32'h00BBAA00);
        check("ro_ptr_wrap", 32'(ptr_out), 32'h0);
        strobe(4'b0100);
        check("txdone_in_write", 32'(ptr_out), 32'h0);
        send_addr(8'h84);
        send_rx(8'h09);
        send_rx(8'h12);
        check("oor_no_stb", 32'(reg_wr_stb), 32'h0);
        check("oor_ptr_hold_wr", 32'(ptr_out), 32'h9);
        check("oor_regs", regs_out, 32'h00BBAA00);
        send_addr(8'h85);
        idle_cyc();
        check("oor_tx_ff", 32'(bus.i2c_data_tx), 32'hFF);
        strobe(4'b0100);
        check("oor_ptr_hold_rd", 32'(ptr_out), 32'h9);

        // Error beats a coincident rx byte
        send_addr(8'h84);
        send_rx(8'h00);
        send_rx(8'h3C);
        check("wr_reg0", regs_out, 32'h00BBAA3C);
        bus.i2c_data_rx = 8'h77;
        strobe(4'b1010);
        check("err_no_stb", 32'(reg_wr_stb), 32'h0);
        check("err_regs",   regs_out, 32'h00BBAA3C);
        check("err_ptr",    32'(ptr_out), 32'h1);
        send_rx(8'h66);
        check("idle_rx_ign_regs", regs_out, 32'h00BBAA3C);
        check("idle_rx_ign_ptr",  32'(ptr_out), 32'h1);

        // Address strobe beats a coincident rx byte, then repeated START keeps pointer
        send_addr(8'h84);
        bus.i2c_addr_rw = 8'h84;
        bus.i2c_data_rx = 8'h02;
        strobe(4'b0011);
        check("addr_prio_ptr", 32'(ptr_out), 32'h1);
        send_rx(8'h02);
        check("getptr_after_addr", 32'(ptr_out), 32'h2);
        send_addr(8'h85);
        idle_cyc();
        check("rstart_ptr", 32'(ptr_out), 32'h2);
        check("rstart_tx",  32'(bus.i2c_data_tx), 32'hBB);

        // Asynchronous reset between edges while a write strobe is up
        send_addr(8'h84);
        send_rx(8'h00);
        send_rx(8'h3C);
        check("pre_rst_stb", 32'(reg_wr_stb), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_regs", regs_out, 32'h0);
        check("arst_ptr",  32'(ptr_out), 32'h0);
        check("arst_stb",  32'(reg_wr_stb), 32'h0);
        check("arst_tx",   32'(bus.i2c_data_tx), 32'h0);
        bus.i2c_data_rx           = 8'h55;
        bus.i2c_data_rx_valid_stb = 1'b1;
        #10 rst_n = 1'b1;
        idle_cyc();
        bus.i2c_data_rx_valid_stb = 1'b0;
        check("post_rst_regs", regs_out, 32'h0);
        check("post_rst_stb",  32'(reg_wr_stb), 32'h0);
        check("post_rst_ptr",  32'(ptr_out), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_reg_bank.md
I2C_REG_BANK -- requirements
Module: i2c_reg_bank

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 8, legal 2..128: number of 8-bit registers.
REQ-002 The block SHALL have parameter WR_MASK, default all ones (NUM_REGS bits); bit k=1 makes register k I2C-writable, bit k=0 makes register k a read-only status register.
REQ-003 The block SHALL have parameter RESET_VALS, default 0 (NUM_REGS*8 bits); reset value of register k is bits [8k+7:8k].
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 i2c_addr_rw  input  8  {7-bit address, R/W}; bit0=1 is read.
REQ-007 i2c_addr_rw_valid_stb  input  1  one-cycle pulse: address byte matched, transaction start.
REQ-008 i2c_data_rx  input  8  received data byte.
REQ-009 i2c_data_rx_valid_stb  input  1  one-cycle pulse: i2c_data_rx valid.
REQ-010 i2c_data_tx  output  8  byte offered to slave for transmission.
REQ-011 i2c_data_tx_done_stb  input  1  one-cycle pulse: byte transmitted to master.
REQ-012 i2c_error_stb  input  1  one-cycle pulse: bus error or unexpected STOP/START.
REQ-013 status_in  input  NUM_REGS*8  read value of non-writable register k at bits [8k+7:8k].
REQ-014 regs_out  output  NUM_REGS*8  current contents of all writable registers; non-writable slots drive RESET_VALS.
REQ-015 reg_wr_stb  output  NUM_REGS  one-cycle pulse on bit k when register k is written over I2C.
REQ-016 ptr_out  output  8  current register pointer.

Function
REQ-017 The block SHALL implement states IDLE, GET_PTR, WRITE, READ.
REQ-018 In any state, i2c_addr_rw_valid_stb SHALL move to GET_PTR if bit0=0, or to READ if bit0=1; pointer unchanged.
REQ-019 In GET_PTR, i2c_data_rx_valid_stb SHALL load pointer with i2c_data_rx (full 8 bits) and move to WRITE.
REQ-020 In WRITE, i2c_data_rx_valid_stb SHALL, when pointer < NUM_REGS and WR_MASK[pointer]=1, load register[pointer] with the byte and pulse reg_wr_stb[pointer] on the same edge the register updates (regs_out and strobe visible together, 1-cycle latency).
REQ-021 In WRITE, a byte addressed to a non-writable or out-of-range register SHALL be dropped with no strobe; the pointer still advances.
REQ-022 In READ, i2c_data_tx_done_stb SHALL advance the pointer.
REQ-023 Pointer advance: pointer = NUM_REGS-1 wraps to 0; pointer < NUM_REGS-1 increments by 1; pointer >= NUM_REGS stays unchanged.
REQ-024 i2c_data_tx SHALL be registered and refreshed every cycle: register[pointer] if writable, status_in slot if non-writable, 8'hFF if pointer >= NUM_REGS; it is valid 1 cycle after any pointer change.
REQ-025 i2c_error_stb SHALL move to IDLE, leave pointer unchanged, and take priority over any rx/tx/addr strobe in the same cycle (that strobe ignored, no write).
REQ-026 i2c_data_rx_valid_stb in IDLE or READ and i2c_data_tx_done_stb outside READ SHALL be ignored.
REQ-027 i2c_addr_rw_valid_stb coincident with a data strobe SHALL take priority; the data strobe is ignored.
REQ-028 A new transaction (repeated START) SHALL retain the pointer, so write-pointer-then-read returns the addressed register.

Reset
REQ-029 While rst_n=0, state=IDLE, pointer=0, registers=RESET_VALS, reg_wr_stb=0, i2c_data_tx=8'h00, regardless of clk.
REQ-030 Reset asserted mid-transaction SHALL abandon it; the first clocked cycle after release samples no pending write.

Verification (NUM_REGS=4, WR_MASK=4'b0111, RESET_VALS=0)
REQ-031 Write: addr 0x84, rx 0x01, rx 0xAA, rx 0xBB -> reg1=0xAA, reg2=0xBB, reg_wr_stb pulses 4'b0010 then 4'b0100, ptr_out=3.
REQ-032 Read with wrap: status_in slot3=0x5C, pointer=3, addr 0x85, two tx_done -> i2c_data_tx 0x5C, then reg0 value, ptr_out 0 then 1.
REQ-033 Protection/range: write pointer 0x03 then 0x11 -> no strobe, reg3 unchanged, ptr=0; write pointer 0x09 then read -> i2c_data_tx=0xFF, ptr stays 0x09.
REQ-034 Error priority: error_stb and rx_valid_stb (0x77) same cycle in WRITE -> no register change, state IDLE, later rx ignored.
REQ-035 Async reset: rst_n low between clock edges after writing reg0=0x3C -> reg0=0x00, ptr_out=0, reg_wr_stb=0 immediately.
